// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multi-cycle controller that steps a single-cycle datapath against a
// synchronous instruction memory. Each instruction goes through
// FETCH -> WAIT (MEM_LAT cycles) -> EXEC. The EXEC cycle raises commit,
// which enables the register-file write and the PC advance.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   run        level; instructions execute back to back while high
//   step       one-cycle pulse; executes exactly one instruction from IDLE
//   imem_addr  word address to instruction memory (pc[ADDR_W+1:2])
//   imem_rd    read strobe, high only in FETCH
//   imem_data  instruction memory read data
//   pc_load    redirect request from the datapath, sampled in EXEC
//   pc_target  redirect target, sampled in EXEC
//   pc         current PC
//   instr      latched instruction, held until the next latch
//   commit     high for the EXEC cycle only
//   busy       high in FETCH, WAIT and EXEC
//   halted     high in HALT
//   fault      sticky; set by a misaligned redirect
//   retired    count of committed instructions (wraps)

module fetch_sequencer #(
  parameter int          ADDR_W   = 8,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [31:0]       imem_data,
  input  logic              pc_load,
  input  logic [31:0]       pc_target,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              commit,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       retired
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [2:0]  LAT    = 3'(MEM_LAT);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [2:0] wait_cnt;
  logic       misaligned;

  // A redirect to a non-word-aligned target stops the machine instead of
  // updating the PC.
  assign misaligned = pc_load && (pc_target[1:0] != 2'b00);

  assign imem_addr = pc[ADDR_W+1:2];
  assign imem_rd   = (state == S_FETCH);
  assign commit    = (state == S_EXEC);
  assign busy      = (state == S_FETCH) || (state == S_WAIT) || (state == S_EXEC);
  assign halted    = (state == S_HALT);

  // Next-state logic. run wins over step in IDLE, and step is simply not
  // looked at in any other state, so pulses outside IDLE are dropped.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (run || step) next_state = S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT:  if (wait_cnt == 3'd1) next_state = S_EXEC;
      S_EXEC: begin
        if (instr == EBREAK || misaligned) next_state = S_HALT;
        else if (run)                      next_state = S_FETCH;
        else                               next_state = S_IDLE;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // State, wait counter, instruction latch, PC, fault and retire counter.
  // The instruction is captured in the last WAIT cycle, when the memory
  // data for the FETCH address has just become valid, so it is stable for
  // the whole EXEC cycle. PC only moves at the end of EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      instr    <= NOP;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      retired  <= 32'd0;
    end else begin
      state <= next_state;
      case (state)
        S_FETCH: wait_cnt <= LAT;
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) instr <= imem_data;
        end
        S_EXEC: begin
          retired <= retired + 32'd1;
          if (instr != EBREAK) begin
            if (misaligned)   fault <= 1'b1;
            else if (pc_load) pc    <= pc_target;
            else              pc    <= pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
